// File: rtl/model_read_keys_stream.sv
// Streams one R x W key matrix from K_IN to K_OUT through a small FIFO, tagging each element with its row-major indices.
// Optional build macro MODEL_READ_KEYS_STREAM_CLAMP_EN saturates keys to [-KEY_LIMIT, +KEY_LIMIT] before buffering.
module model_read_keys_stream #(
    parameter int                   DATA_SIZE    = 64,
    parameter int                   CONTROL_SIZE = 64,
    parameter int                   FIFO_DEPTH   = 4,
    parameter logic [DATA_SIZE-1:0] KEY_LIMIT    = {2'b01, {(DATA_SIZE-2){1'b0}}}
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    output logic                    BUSY,
    output logic                    ERROR,
    input  logic [CONTROL_SIZE-1:0] SIZE_R_IN,
    input  logic [CONTROL_SIZE-1:0] SIZE_W_IN,
    input  logic [DATA_SIZE-1:0]    K_IN,
    input  logic                    K_IN_VALID,
    output logic                    K_IN_READY,
    output logic [DATA_SIZE-1:0]    K_OUT,
    output logic                    K_OUT_VALID,
    input  logic                    K_OUT_READY,
    output logic [CONTROL_SIZE-1:0] K_OUT_I_INDEX,
    output logic [CONTROL_SIZE-1:0] K_OUT_K_INDEX,
    output logic                    K_OUT_I_LAST,
    output logic                    K_OUT_K_LAST
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [DATA_SIZE-1:0]    key;
        logic [CONTROL_SIZE-1:0] i_idx;
        logic [CONTROL_SIZE-1:0] k_idx;
        logic                    i_last;
        logic                    k_last;
    } entry_t;

    state_t                  state_q;
    logic [CONTROL_SIZE-1:0] size_r_q, size_w_q;
    logic [CONTROL_SIZE-1:0] i_q, k_q, i_d, k_d;
    logic                    ready_q, error_q;

    entry_t                  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q;

    logic                    fifo_full, fifo_empty;
    logic                    k_in_ready, push, pop;
    logic                    i_last, k_last;
    logic [DATA_SIZE-1:0]    key_c;
    entry_t                  push_entry, head;

`ifdef MODEL_READ_KEYS_STREAM_CLAMP_EN
    logic signed [DATA_SIZE-1:0] key_s, lim_s;

    always_comb begin
        key_s = signed'(K_IN);
        lim_s = signed'(KEY_LIMIT);
        key_c = K_IN;
        if (key_s > lim_s)
            key_c = KEY_LIMIT;
        else if (key_s < -lim_s)
            key_c = -KEY_LIMIT;
    end
`else
    assign key_c = K_IN;
`endif

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
        fifo_empty = (count_q == '0);
        k_in_ready = (state_q == S_RUN) && !fifo_full;
        push       = K_IN_VALID && k_in_ready;
        pop        = !fifo_empty && K_OUT_READY;

        i_last = (i_q == size_r_q - CONTROL_SIZE'(1));
        k_last = (k_q == size_w_q - CONTROL_SIZE'(1));
        k_d    = k_last ? '0 : k_q + CONTROL_SIZE'(1);
        i_d    = k_last ? i_q + CONTROL_SIZE'(1) : i_q;

        push_entry.key    = key_c;
        push_entry.i_idx  = i_q;
        push_entry.k_idx  = k_q;
        push_entry.i_last = i_last;
        push_entry.k_last = k_last;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            size_r_q <= '0;
            size_w_q <= '0;
            i_q      <= '0;
            k_q      <= '0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        if (SIZE_R_IN == '0 || SIZE_W_IN == '0) begin
                            error_q <= 1'b1;
                            ready_q <= 1'b1;
                        end else begin
                            size_r_q <= SIZE_R_IN;
                            size_w_q <= SIZE_W_IN;
                            i_q      <= '0;
                            k_q      <= '0;
                            state_q  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (push) begin
                        i_q <= i_d;
                        k_q <= k_d;
                        if (i_last && k_last)
                            state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // READY rises together with DONE so the pulse lines up with that single cycle.
                    if (fifo_empty) begin
                        state_q <= S_DONE;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is not reset; outputs are masked while empty, so stale entries are never visible.
    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr_q] <= push_entry;
    end

    assign head = mem[rd_ptr_q];

    always_comb begin
        K_OUT         = '0;
        K_OUT_I_INDEX = '0;
        K_OUT_K_INDEX = '0;
        K_OUT_I_LAST  = 1'b0;
        K_OUT_K_LAST  = 1'b0;
        if (!fifo_empty) begin
            K_OUT         = head.key;
            K_OUT_I_INDEX = head.i_idx;
            K_OUT_K_INDEX = head.k_idx;
            K_OUT_I_LAST  = head.i_last;
            K_OUT_K_LAST  = head.k_last;
        end
    end

    assign READY       = ready_q;
    assign ERROR       = error_q;
    assign BUSY        = (state_q != S_IDLE);
    assign K_IN_READY  = k_in_ready;
    assign K_OUT_VALID = !fifo_empty;

endmodule

// File: tb/tb_model_read_keys_stream.sv
// Scoreboard bench for model_read_keys_stream: expected elements queued on input acceptance, compared on output transfer.
module tb_model_read_keys_stream;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int FD = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          START = 1'b0;
    logic          READY, BUSY, ERROR;
    logic [CW-1:0] SIZE_R_IN = '0;
    logic [CW-1:0] SIZE_W_IN = '0;
    logic [DW-1:0] K_IN = '0;
    logic          K_IN_VALID = 1'b0;
    logic          K_IN_READY;
    logic [DW-1:0] K_OUT;
    logic          K_OUT_VALID;
    logic          K_OUT_READY = 1'b0;
    logic [CW-1:0] K_OUT_I_INDEX, K_OUT_K_INDEX;
    logic          K_OUT_I_LAST, K_OUT_K_LAST;

    always #5 CLK = ~CLK;

    model_read_keys_stream #(
        .DATA_SIZE   (DW),
        .CONTROL_SIZE(CW),
        .FIFO_DEPTH  (FD),
        .KEY_LIMIT   (16'd100)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .START        (START),
        .READY        (READY),
        .BUSY         (BUSY),
        .ERROR        (ERROR),
        .SIZE_R_IN    (SIZE_R_IN),
        .SIZE_W_IN    (SIZE_W_IN),
        .K_IN         (K_IN),
        .K_IN_VALID   (K_IN_VALID),
        .K_IN_READY   (K_IN_READY),
        .K_OUT        (K_OUT),
        .K_OUT_VALID  (K_OUT_VALID),
        .K_OUT_READY  (K_OUT_READY),
        .K_OUT_I_INDEX(K_OUT_I_INDEX),
        .K_OUT_K_INDEX(K_OUT_K_INDEX),
        .K_OUT_I_LAST (K_OUT_I_LAST),
        .K_OUT_K_LAST (K_OUT_K_LAST)
    );

    typedef struct packed {
        logic [DW-1:0] key;
        logic [CW-1:0] i_idx;
        logic [CW-1:0] k_idx;
        logic          i_last;
        logic          k_last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0;
    int   ready_cnt = 0, error_cnt = 0, out_cnt = 0, acc_cnt = 0, stall_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_key(input logic [DW-1:0] d);
`ifdef MODEL_READ_KEYS_STREAM_CLAMP_EN
        logic signed [DW-1:0] s;
        s = signed'(d);
        if (s > 16'sd100)
            return 16'd100;
        if (s < -16'sd100)
            return 16'hFF9C;
`endif
        return d;
    endfunction

    // Output monitor: pulse counters and scoreboard comparison, sampled mid-cycle.
    always @(negedge CLK) begin
        exp_t e;
        if (READY) ready_cnt++;
        if (ERROR) error_cnt++;
        if (K_IN_VALID && !K_IN_READY) stall_cnt++;
        if (K_OUT_VALID && K_OUT_READY) begin
            check("out_expected", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("k_out", 64'(K_OUT), 64'(e.key));
                check("k_out_tags",
                      64'({K_OUT_I_INDEX, K_OUT_K_INDEX, K_OUT_I_LAST, K_OUT_K_LAST}),
                      64'({e.i_idx, e.k_idx, e.i_last, e.k_last}));
            end
            out_cnt++;
        end
    end

    // All driving tasks are entered and left just after a rising edge.
    task automatic start_xfer(input int r, input int w);
        SIZE_R_IN = CW'(r);
        SIZE_W_IN = CW'(w);
        START     = 1'b1;
        @(posedge CLK); #1;
        START     = 1'b0;
    endtask

    task automatic send_elem(input logic [DW-1:0] d, input int idx, input int r, input int w);
        int   n;
        int   i, k;
        exp_t e;
        n = 0;
        i = idx / w;
        k = idx % w;
        K_IN       = d;
        K_IN_VALID = 1'b1;
        @(negedge CLK);
        while (!K_IN_READY && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (K_IN_READY) begin
            e.key    = exp_key(d);
            e.i_idx  = CW'(i);
            e.k_idx  = CW'(k);
            e.i_last = (i == r - 1);
            e.k_last = (k == w - 1);
            sb.push_back(e);
            acc_cnt++;
        end else begin
            check("kin_accept_timeout", 64'(K_IN_READY), 64'(1));
        end
        @(posedge CLK); #1;
        K_IN_VALID = 1'b0;
    endtask

    task automatic wait_done();
        int r0, c;
        r0 = ready_cnt;
        c  = 0;
        while (ready_cnt == r0 && c < 300) begin
            @(negedge CLK);
            c++;
        end
        check("ready_seen", 64'(ready_cnt != r0), 64'(1));
        @(posedge CLK); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"},
              64'({READY, BUSY, ERROR, K_IN_READY, K_OUT_VALID, K_OUT_I_LAST, K_OUT_K_LAST}), 64'(0));
        check({tag, "_kout"}, 64'(K_OUT), 64'(0));
        check({tag, "_idx"}, 64'({K_OUT_I_INDEX, K_OUT_K_INDEX}), 64'(0));
    endtask

    initial begin
        int r0, o0, a0, s0, e0;

        // Reset state
        #1 RST = 1'b1;
        #2 check_all_zero("reset");
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;

        // 2x3 matrix, full throughput
        K_OUT_READY = 1'b1;
        r0 = ready_cnt; o0 = out_cnt; s0 = stall_cnt;
        start_xfer(2, 3);
        check("busy_run", 64'(BUSY), 64'(1));
        for (int idx = 0; idx < 6; idx++)
            send_elem(DW'(idx + 1), idx, 2, 3);
        wait_done();
        repeat (3) @(negedge CLK);
        check("t1_ready_once", 64'(ready_cnt - r0), 64'(1));
        check("t1_out_count", 64'(out_cnt - o0), 64'(6));
        check("t1_no_stall", 64'(stall_cnt - s0), 64'(0));
        check("t1_idle", 64'(BUSY), 64'(0));
        @(posedge CLK); #1;

        // Backpressure: 1x8 with output stalled
        K_OUT_READY = 1'b0;
        a0 = acc_cnt; o0 = out_cnt; r0 = ready_cnt;
        start_xfer(1, 8);
        fork
            begin
                for (int idx = 0; idx < 8; idx++)
                    send_elem(DW'(10 + idx), idx, 1, 8);
            end
            begin
                repeat (8) @(negedge CLK);
                check("t2_acc_full", 64'(acc_cnt - a0), 64'(FD));
                check("t2_kin_ready_low", 64'(K_IN_READY), 64'(0));
                check("t2_head_valid", 64'(K_OUT_VALID), 64'(1));
                check("t2_head_held", 64'(K_OUT), 64'(exp_key(16'd10)));
                @(posedge CLK); #1;
                K_OUT_READY = 1'b1;
            end
        join
        wait_done();
        repeat (2) @(negedge CLK);
        check("t2_out_count", 64'(out_cnt - o0), 64'(8));
        check("t2_sb_empty", 64'(sb.size()), 64'(0));
        check("t2_ready_once", 64'(ready_cnt - r0), 64'(1));
        @(posedge CLK); #1;

        // Zero-size START: R=0 then W=0
        r0 = ready_cnt; e0 = error_cnt;
        start_xfer(0, 4);
        @(negedge CLK);
        check("t3_error_pulse", 64'({ERROR, READY}), 64'(2'b11));
        check("t3_busy", 64'({BUSY, K_OUT_VALID}), 64'(0));
        @(negedge CLK);
        check("t3_error_clear", 64'({ERROR, READY, BUSY, K_OUT_VALID}), 64'(0));
        @(posedge CLK); #1;
        start_xfer(3, 0);
        repeat (3) @(negedge CLK);
        check("t3_error_count", 64'(error_cnt - e0), 64'(2));
        check("t3_ready_count", 64'(ready_cnt - r0), 64'(2));
        @(posedge CLK); #1;

        // Reset mid-transfer, then a fresh 1x2 transfer
        K_OUT_READY = 1'b0;
        start_xfer(2, 3);
        for (int idx = 0; idx < 3; idx++)
            send_elem(DW'(21 + idx), idx, 2, 3);
        check("t4_pre_valid", 64'(K_OUT_VALID), 64'(1));
        RST = 1'b1;
        #1 check_all_zero("t4_reset");
        sb.delete();
        r0 = ready_cnt;
        #2 RST = 1'b0;
        repeat (5) @(negedge CLK);
        check("t4_no_ready", 64'(ready_cnt - r0), 64'(0));
        check("t4_idle", 64'({BUSY, K_OUT_VALID}), 64'(0));
        @(posedge CLK); #1;
        K_OUT_READY = 1'b1;
        o0 = out_cnt;
        start_xfer(1, 2);
        send_elem(16'd31, 0, 1, 2);
        send_elem(16'd32, 1, 1, 2);
        wait_done();
        repeat (2) @(negedge CLK);
        check("t4_out_count", 64'(out_cnt - o0), 64'(2));
        @(posedge CLK); #1;

        // Clamp boundary values
        o0 = out_cnt;
        start_xfer(1, 3);
        send_elem(16'd500, 0, 1, 3);
        send_elem(16'hFE0C, 1, 1, 3);
        send_elem(16'd7, 2, 1, 3);
        wait_done();
        repeat (2) @(negedge CLK);
        check("t5_out_count", 64'(out_cnt - o0), 64'(3));
        @(posedge CLK); #1;

        // START during RUN is ignored
        r0 = ready_cnt; o0 = out_cnt;
        start_xfer(2, 2);
        send_elem(16'd41, 0, 2, 2);
        send_elem(16'd42, 1, 2, 2);
        start_xfer(5, 5);
        check("t6_busy", 64'(BUSY), 64'(1));
        send_elem(16'd43, 2, 2, 2);
        send_elem(16'd44, 3, 2, 2);
        wait_done();
        repeat (5) @(negedge CLK);
        check("t6_ready_once", 64'(ready_cnt - r0), 64'(1));
        check("t6_out_count", 64'(out_cnt - o0), 64'(4));
        check("t6_idle", 64'({BUSY, K_IN_READY, K_OUT_VALID}), 64'(0));
        check("sb_final_empty", 64'(sb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
